alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 A  input  8  operand A, unsigned.
REQ-005 B  input  8  operand B, unsigned.
REQ-006 ALU_Sel  input  4  operation select, sampled on each rising clk edge.
REQ-007 ALU_out  output  8  registered result.

Function
REQ-008 On every rising clk edge with rst_n high, ALU_out SHALL load the result of the operation selected by ALU_Sel on the current A and B; latency is exactly 1 cycle, with a new result every cycle.
REQ-009 All arithmetic SHALL be unsigned modulo 256; carries, borrows and upper product bits SHALL be discarded.
REQ-010 An internal 8-bit accumulator ACC SHALL exist; ACC SHALL change only under MAC or reset.
REQ-011 The opcode map SHALL be:
- 0000 ADD: A+B
- 0001 MAC: ACC+A*B; ACC and ALU_out both load this value on the same edge
- 0010 SUB: A-B
- 0011 MUL: low 8 bits of A*B
- 0100 AND: A&B
- 0101 OR: A|B
- 0110 XOR: A^B
- 0111 ROR: A rotated right 1 (A[0] into bit 7)
- 1000 ROL: A rotated left 1 (A[7] into bit 0)
- 1001 SHL: A<<1, zero fill
- 1010 SHR: A>>1 logical, zero fill
- 1011 NOT: ~A
- 1100 INC: A+1
- 1101 DEC: A-1
- 1110 EQU: 0x01 if A==B, else 0x00
- 1111 LTH: 0x01 if A<B (unsigned), else 0x00
REQ-012 All 16 codes SHALL be defined; no opcode SHALL leave ALU_out unchanged.
REQ-013 MAC held for N consecutive edges SHALL accumulate N times.
REQ-014 Wrap-around boundaries SHALL behave as follows:
- INC 0xFF -> 0x00
- DEC 0x00 -> 0xFF
- SUB 0x00-0x01 -> 0xFF
- ADD 0xFF+0x01 -> 0x00
REQ-015 Comparison boundaries SHALL behave as follows:
- LTH with A==B -> 0x00
- EQU with A==B -> 0x01
REQ-016 Inputs changing between edges SHALL have no effect on ALU_out until the next rising edge; there is no combinational path from the inputs to ALU_out.

Reset
REQ-017 While rst_n is low, ALU_out SHALL be 0x00 and ACC SHALL be 0x05, immediately and independent of clk.
REQ-018 Assertion of rst_n mid-operation SHALL abort any accumulation; after release, the first MAC SHALL start from ACC=0x05.
REQ-019 The first rising edge after rst_n deasserts SHALL perform a normal operation.

Verification
REQ-020 A=0x4D, B=0x17, ALU_Sel=0000, one edge -> ALU_out=0x64.
REQ-021 After reset, A=0x4D, B=0x17, ALU_Sel=0001: first edge -> ALU_out=0xF0; second edge -> ALU_out=0xDB.
REQ-022 A=0x4D, ALU_Sel=0111 -> ALU_out=0xA6; ALU_Sel=1000 -> ALU_out=0x9A.
REQ-023 A=0x4D, B=0x17, ALU_Sel=1111 -> ALU_out=0x00; A=0x17, B=0x4D -> ALU_out=0x01; A=B=0x4D -> ALU_out=0x00.
REQ-024 Sequence MAC, MAC, then rst_n low between edges -> ALU_out=0x00 at once; after release, MAC with A=0x4D, B=0x17 -> ALU_out=0xF0.
REQ-025 Boundary sweep: INC A=0xFF -> 0x00; DEC A=0x00 -> 0xFF; SUB A=0x00, B=0x01 -> 0xFF; EQU A=B=0x5A -> 0x01.

Source files
------------

// File: rtl/alu.sv
// 8-bit registered ALU with a multiply-accumulate register.
// ALU_out and the accumulator update on the rising clk edge; there is one cycle of latency.
module alu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [3:0] ALU_Sel,
    output logic [7:0] ALU_out
);

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_MAC = 4'b0001,
        OP_SUB = 4'b0010,
        OP_MUL = 4'b0011,
        OP_AND = 4'b0100,
        OP_OR  = 4'b0101,
        OP_XOR = 4'b0110,
        OP_ROR = 4'b0111,
        OP_ROL = 4'b1000,
        OP_SHL = 4'b1001,
        OP_SHR = 4'b1010,
        OP_NOT = 4'b1011,
        OP_INC = 4'b1100,
        OP_DEC = 4'b1101,
        OP_EQU = 4'b1110,
        OP_LTH = 4'b1111
    } op_e;

    localparam logic [7:0] ACC_RESET = 8'h05;

    logic [7:0] alu_out_q, alu_out_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] prod_lo;
    op_e        op;

    // Only the low byte of the product is ever used, so an 8-bit result is enough.
    assign prod_lo = A * B;
    assign op      = op_e'(ALU_Sel);

    always_comb begin
        alu_out_d = 8'h00;
        acc_d     = acc_q;
        case (op)
            OP_ADD: alu_out_d = A + B;
            OP_MAC: begin
                acc_d     = acc_q + prod_lo;
                alu_out_d = acc_q + prod_lo;
            end
            OP_SUB: alu_out_d = A - B;
            OP_MUL: alu_out_d = prod_lo;
            OP_AND: alu_out_d = A & B;
            OP_OR:  alu_out_d = A | B;
            OP_XOR: alu_out_d = A ^ B;
            OP_ROR: alu_out_d = {A[0], A[7:1]};
            OP_ROL: alu_out_d = {A[6:0], A[7]};
            OP_SHL: alu_out_d = {A[6:0], 1'b0};
            OP_SHR: alu_out_d = {1'b0, A[7:1]};
            OP_NOT: alu_out_d = ~A;
            OP_INC: alu_out_d = A + 8'd1;
            OP_DEC: alu_out_d = A - 8'd1;
            OP_EQU: alu_out_d = {7'd0, (A == B)};
            OP_LTH: alu_out_d = {7'd0, (A < B)};
            default: alu_out_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q <= 8'h00;
            acc_q     <= ACC_RESET;
        end else begin
            alu_out_q <= alu_out_d;
            acc_q     <= acc_d;
        end
    end

    assign ALU_out = alu_out_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: hand-computed vectors checked with immediate assertions.
module tb_alu;

    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    logic [7:0] ALU_out;

    int n_checks = 0;
    int n_fail   = 0;

    alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .ALU_Sel (ALU_Sel),
        .ALU_out (ALU_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] expected);
        n_checks++;
        assert (ALU_out === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, ALU_out, expected);
        end
        $display("check %-14s ALU_out=%h expected=%h", tag, ALU_out, expected);
    endtask

    // Drive operands, take one rising edge, then sample just after it.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                        input string tag, input logic [7:0] expected);
        A       = a;
        B       = b;
        ALU_Sel = sel;
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        A       = 8'h00;
        B       = 8'h00;
        ALU_Sel = 4'b0000;
        #1;
        check("reset", 8'h00);
        @(posedge clk);
        #1;
        check("reset_hold", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // MAC from the reset accumulator value, then accumulate again
        step(8'h4D, 8'h17, 4'b0001, "mac1", 8'hF0);
        step(8'h4D, 8'h17, 4'b0001, "mac2", 8'hDB);

        // Asynchronous reset between edges aborts accumulation
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h4D, 8'h17, 4'b0001, "mac_after_rst", 8'hF0);

        step(8'h4D, 8'h17, 4'b0000, "add", 8'h64);
        step(8'h4D, 8'h17, 4'b0010, "sub", 8'h36);
        step(8'h4D, 8'h17, 4'b0011, "mul", 8'hEB);
        step(8'h4D, 8'h17, 4'b0100, "and", 8'h05);
        step(8'h4D, 8'h17, 4'b0101, "or", 8'h5F);
        step(8'h4D, 8'h17, 4'b0110, "xor", 8'h5A);
        step(8'h4D, 8'h17, 4'b0111, "ror", 8'hA6);
        step(8'h4D, 8'h17, 4'b1000, "rol", 8'h9A);
        step(8'hB3, 8'h00, 4'b0111, "ror_b3", 8'hD9);
        step(8'hB3, 8'h00, 4'b1000, "rol_b3", 8'h67);
        step(8'hB3, 8'h00, 4'b1001, "shl_b3", 8'h66);
        step(8'hB3, 8'h00, 4'b1010, "shr_b3", 8'h59);
        step(8'h4D, 8'h00, 4'b1011, "not", 8'hB2);
        step(8'h4D, 8'h00, 4'b1100, "inc", 8'h4E);
        step(8'h4D, 8'h00, 4'b1101, "dec", 8'h4C);
        step(8'h4D, 8'h17, 4'b1110, "equ_ne", 8'h00);
        step(8'h4D, 8'h17, 4'b1111, "lth_gt", 8'h00);
        step(8'h17, 8'h4D, 4'b1111, "lth_lt", 8'h01);
        step(8'h4D, 8'h4D, 4'b1111, "lth_eq", 8'h00);
        step(8'h4D, 8'h4D, 4'b1110, "equ_eq", 8'h01);

        // Wrap-around boundaries
        step(8'hFF, 8'h00, 4'b1100, "inc_wrap", 8'h00);
        step(8'h00, 8'h00, 4'b1101, "dec_wrap", 8'hFF);
        step(8'h00, 8'h01, 4'b0010, "sub_wrap", 8'hFF);
        step(8'hFF, 8'h01, 4'b0000, "add_wrap", 8'h00);
        step(8'h5A, 8'h5A, 4'b1110, "equ_5a", 8'h01);

        // Accumulator held at 0xF0 through the non-MAC ops; three back-to-back MACs
        step(8'h01, 8'h01, 4'b0001, "mac_hold", 8'hF1);
        step(8'h01, 8'h02, 4'b0001, "mac_n1", 8'hF3);
        step(8'h01, 8'h02, 4'b0001, "mac_n2", 8'hF5);
        step(8'h01, 8'h02, 4'b0001, "mac_n3", 8'hF7);
        step(8'h10, 8'h10, 4'b0001, "mac_wrap", 8'hF7);

        // Inputs changing between edges must not reach the output
        step(8'h4D, 8'h17, 4'b0000, "add_pre", 8'h64);
        A       = 8'hFF;
        B       = 8'hFF;
        ALU_Sel = 4'b1011;
        #3;
        check("no_comb_path", 8'h64);
        @(posedge clk);
        #1;
        check("not_ff", 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
